// File: rtl/ro_top_rng.sv
// ro_top_rng: ring-oscillator TRNG (clk, async rst, en in; registered random byte d_out) via synced XOR taps, von Neumann debias, 8-bit packing
module ro_top_rng #(
  parameter int NUM_RO     = 4,
  parameter int RO_STAGES  = 5,
  parameter int BASE_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] d_out
);
  timeunit 1ns;
  timeprecision 1ps;
  logic              ring_en;
  logic [NUM_RO-1:0] tap;
  logic [NUM_RO-1:0] sync1;
  logic [NUM_RO-1:0] sync2;
  logic              raw_bit;
  logic              phase;
  logic              first;
  logic [2:0]        cnt;
  logic [7:0]        shreg;
  assign ring_en = en & ~rst;
  genvar r, s;
  generate
    for (r = 0; r < NUM_RO; r++) begin : g_ro
      (* keep = "true", dont_touch = "true" *) logic [RO_STAGES-1:0] st;
      assign #(BASE_DELAY + r) st[0] = ~(ring_en & st[RO_STAGES-1]);
      for (s = 1; s < RO_STAGES; s++) begin : g_st
        assign #(BASE_DELAY + r) st[s] = ~st[s-1];
      end
      assign tap[r] = st[RO_STAGES-1];
    end
  endgenerate
  assign raw_bit = ^sync2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      phase <= 1'b0;
      first <= 1'b0;
      cnt   <= 3'd0;
      shreg <= 8'h00;
      d_out <= 8'h00;
    end else begin
      sync1 <= tap;
      sync2 <= sync1;
      if (!en) begin
        phase <= 1'b0;
        cnt   <= 3'd0;
        shreg <= 8'h00;
      end else begin
        phase <= ~phase;
        if (!phase) first <= raw_bit;
        else if (raw_bit != first) begin
          shreg <= {shreg[6:0], first};
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) d_out <= {shreg[6:0], first};
        end
      end
    end
  end
endmodule

// File: tb/tb_ro_top_rng.sv
// tb_ro_top_rng: scoreboard bench for ro_top_rng with forced raw bit patterns and a free-running statistics run
module tb_ro_top_rng;
  timeunit 1ns;
  timeprecision 1ps;
  typedef struct {
    logic [7:0] val;
    int         cyc;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] d_out;
  logic [7:0] prev = 8'h00;
  logic [3:0] tap0;
  logic       tap_changed;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         mode = 0;
  int         last_upd = 0;
  int         n_upd = 0;
  int         ones [8];
  exp_t       exp_q [$];
  exp_t       e;
  ro_top_rng dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .d_out(d_out)
  );
  always #6.173 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  task automatic drive(input logic [3:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      if (pat[k % 4]) force dut.raw_bit = 1'b1;
      else force dut.raw_bit = 1'b0;
      @(negedge clk);
    end
  endtask
  always @(negedge clk) begin
    if (d_out !== prev) begin
      if (mode == 1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_update: d_out %h at cycle %0d, required no change from %h", d_out, cyc, prev);
        end else begin
          e = exp_q.pop_front();
          if (d_out !== e.val || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL byte_update: got %h at cycle %0d, required %h at cycle %0d", d_out, cyc, e.val, e.cyc);
          end
        end
      end else if (mode == 2) begin
        n_upd++;
        n_cmp++;
        if (cyc - last_upd < 16) begin
          n_bad++;
          $display("FAIL update_spacing: got %0d cycles, required >= 16", cyc - last_upd);
        end
        last_upd = cyc;
        for (int b = 0; b < 8; b++) if (d_out[b]) ones[b]++;
      end
    end
    prev = d_out;
  end
  initial begin
    for (int b = 0; b < 8; b++) ones[b] = 0;
    repeat (5) @(negedge clk);
    chk("reset_dout", d_out, 8'h00);
    rst = 1'b0;
    prev = d_out;
    mode = 1;
    tap0 = dut.tap;
    tap_changed = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (dut.tap !== tap0) tap_changed = 1'b1;
    end
    chk("disabled_tap_const", {7'd0, tap_changed}, 8'h00);
    chk("disabled_dout", d_out, 8'h00);
    exp_q.push_back('{8'hAA, cyc + 16});
    en = 1'b1;
    drive(4'b1001, 40);
    chk("forced_q_empty", 8'(exp_q.size()), 8'h00);
    chk("forced_hold", d_out, 8'hAA);
    drive(4'b1111, 500);
    chk("const_hold", d_out, 8'hAA);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    drive(4'b0101, 10);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("en_low_hold", d_out, 8'hAA);
    exp_q.push_back('{8'hFF, cyc + 16});
    en = 1'b1;
    drive(4'b0101, 40);
    chk("reenable_q_empty", 8'(exp_q.size()), 8'h00);
    chk("reenable_byte", d_out, 8'hFF);
    mode = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", d_out, 8'h00);
    @(posedge clk);
    #1 chk("reset_held", d_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    release dut.raw_bit;
    @(negedge clk);
    prev = d_out;
    last_upd = cyc;
    mode = 2;
    en = 1'b1;
    repeat (20000) @(negedge clk);
    mode = 0;
    n_cmp++;
    if (n_upd < 10) begin
      n_bad++;
      $display("FAIL free_updates: got %0d updates, required >= 10", n_upd);
    end
    for (int b = 0; b < 8; b++) begin
      n_cmp++;
      if (ones[b] * 4 < n_upd || ones[b] * 4 > 3 * n_upd) begin
        n_bad++;
        $display("FAIL bit_balance[%0d]: got %0d ones of %0d bytes, required 25%%..75%%", b, ones[b], n_upd);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ro_top_rng.md
# ro_top_rng

Ring-oscillator true random number generator producing one random byte at a time. Free-running ring oscillators are sampled in the `clk` domain and XOR-combined into a raw bit stream. The stream is von Neumann debiased, then packed 8 bits at a time into the registered output `d_out`. The block sits at the entropy-source level and is consumed by logic that samples `d_out`.

## Interface
- `NUM_RO`, 4: number of ring oscillators; legal range 2..8.
- `RO_STAGES`, 5: inverting stages per ring, counting the enable NAND; must be odd, ≥3.
- `BASE_DELAY`, 1: simulation-only stage delay in time units. Ring i uses `BASE_DELAY + i` per stage so that rings run at distinct frequencies. Synthesis ignores it.
- `clk` input 1: system clock. All registers are clocked on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `en` input 1: enable. 1 means rings oscillate and bits are collected. 0 means rings stop and collection is cleared.
- `d_out` output 8: most recently completed random byte, registered.

## Operation
- **Ring i:**
  - Structure: NAND(`ring_en`, last stage) feeding `RO_STAGES-1` inverters, closed into a loop.
  - `ring_en = en & ~rst`.
  - When `ring_en` is 0, the NAND output is forced to 1 and the ring settles to a static level.
  - The tap is the last inverter output.
  - In simulation each stage carries a `#` delay, so the loop toggles instead of hanging.
  - Mark the loops keep/dont_touch for synthesis.
- **Synchronizer:**
  - Each ring tap passes through a 2-flop synchronizer.
  - Synchronizer flops reset to 0.
- **Raw bit:** `raw_bit` = XOR of all synchronized taps, updated every cycle. `raw_bit` is a named internal net, so benches can force it.
- **Debiaser:**
  - A `phase` flag toggles every cycle while `en`=1.
  - At phase 0, `first` <= `raw_bit`.
  - At phase 1, `raw_bit` is compared with `first`:
    - If they differ, emit `first` as one debiased bit.
    - If they are equal, discard the pair.
- **Packer:**
  - `shreg[7:0]` <= {`shreg[6:0]`, bit} for each emitted bit.
  - 3-bit counter `cnt`.
  - When the 8th bit is emitted (`cnt`==7), `d_out` <= {`shreg[6:0]`, bit} and `cnt` wraps to 0.
  - The first emitted bit of a byte ends up in `d_out[7]`.
- **`en` low (synchronous):**
  - `phase`, `cnt` and `shreg` are cleared.
  - `d_out` holds its last value.
- **Reset:** `rst`=1 clears all registers immediately, without waiting for a clock edge. This covers `d_out`=8'h00, `shreg`, `cnt`, `phase`, `first` and the synchronizers.

## Timing
- Reset values: `d_out`=8'h00, `cnt`=0, `phase`=0.
- Ring start:
  - Rings start oscillating combinationally when `en` rises.
  - A synchronized tap reflects ring activity 2 `clk` edges later.
- Debiaser rate: at most one debiased bit per 2 cycles. A byte therefore needs ≥16 cycles with `en`=1.
- Consecutive `d_out` changes are ≥16 cycles apart.
- Earliest possible `d_out` update after `en` rises: 16 cycles counted from the first phase-0 sample.
- `d_out` changes only on a `clk` rising edge, or asynchronously to 0 on `rst`.
- Events on the same clock edge:
  - `en` falling on the same edge as the 8th bit: `en` wins. No update occurs and the counters clear.
  - `rst` overrides everything.
- Reset mid-byte: the partial byte is lost. Collection restarts at phase 0 once `rst` falls with `en`=1.

## Test plan
- **Async reset:**
  - Stimulus: `en`=1 until `d_out`≠0, then pulse `rst` between clock edges.
  - Required response: `d_out`=8'h00 before the next edge, and it stays 0 while `rst`=1.
- **Disabled:**
  - Stimulus: after reset, `en`=0 for 1000 cycles.
  - Required response: `d_out`=8'h00 throughout; every ring tap constant.
- **Forced pattern:**
  - Stimulus: `en`=1; force `raw_bit` to the repeating sequence 1,0,0,1 aligned to phase 0.
  - Required response: `d_out`=8'hAA exactly 16 cycles after the first sample, and it remains 8'hAA afterwards.
- **Constant input:**
  - Stimulus: force `raw_bit`=1 for 500 cycles.
  - Required response: no `d_out` change.
- **`en` drop mid-byte:**
  - Stimulus: forced 1,0 pairs; drop `en` after 5 emitted bits; re-raise `en`.
  - Required response: `d_out` unchanged while `en`=0. The next update occurs 16 cycles after re-enable and equals 8'hFF.
- **Free-running:**
  - Stimulus: unforced, `en`=1, 20000 cycles.
  - Required response: `d_out` updates ≥10 times, with spacing ≥16 cycles. Across captured bytes, each bit position has a fraction of ones within 0.25–0.75.
